alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Multi-cycle initiator for the datapath ALU: accepts one instruction-level ALU request
//  (5-bit opcode + operands) per handshake and decodes it to the ALU's 4-bit ctrl_sig.
//  Drives the ALU operands, waits the op's settle time (long for mul/div), then captures the
//  64-bit result into Z (z_hi/z_lo). Sits between control unit and ALU; done/err back to control.
// PARAMETERS
//  REG_SIZE     32  operand width; ALU result width is 2*REG_SIZE
//  MULDIV_WAIT  4   EXEC cycles allowed for mul/div settling (legal >= 1)
//  IMM_WIDTH    19  width of immediate field, sign-extended to REG_SIZE
// PORTS
//  clk         in   1           single clock, all state updates on posedge
//  rst_n       in   1           synchronous, active-low reset (sampled on posedge clk)
//  start       in   1           request strobe; accepted only in IDLE
//  opcode      in   5           instruction opcode (table below)
//  a_in        in   REG_SIZE    operand A (Y register value)
//  b_in        in   REG_SIZE    operand B (register value)
//  imm_in      in   IMM_WIDTH   immediate, used by addi/andi/ori
//  alu_ctrl    out  4           ctrl_sig to ALU
//  alu_a       out  REG_SIZE    ALU operand A
//  alu_b       out  REG_SIZE    ALU operand B
//  alu_result  in   2*REG_SIZE  ALU c_data_out
//  z_hi        out  REG_SIZE    captured result high word
//  z_lo        out  REG_SIZE    captured result low word
//  busy        out  1           high whenever state != IDLE
//  done        out  1           one-cycle pulse, request complete
//  err         out  1           valid with done: opcode was illegal
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): state=IDLE, z_hi=z_lo=0, alu_ctrl=0, alu_a=alu_b=0,
//   busy=done=err=0, counter=0. Reset mid-operation aborts; no done is issued.
//  Decode opcode->alu_ctrl: add 00011->0010, sub 00100->0011, and 00101->0000, or 00110->0001,
//   shr 00111->0100, shl 01000->0101, ror 01001->0110, rol 01010->0111, addi 01011->0010,
//   andi 01100->0000, ori 01101->0001, mul 01110->1000, div 01111->1001, neg 10000->1010,
//   not 10001->1011. Every other opcode is illegal.
//  Operand B: addi/andi/ori use sign-extended imm_in; all others use b_in. neg/not use B only.
//  FSM IDLE -> EXEC -> DONE -> IDLE:
//   IDLE: start=1 at posedge latches opcode/a/b/imm; legal: go EXEC, counter=MULDIV_WAIT
//    for mul/div else 1; illegal: go DONE with err set, no ALU op, Z unchanged.
//   EXEC: alu_ctrl/alu_a/alu_b held constant from latched values; counter decrements each
//    posedge; on the posedge where counter==1, capture Z and go DONE.
//   DONE: done=1 for exactly one cycle, err valid; next posedge -> IDLE.
//  Latency: start sampled at edge E0 -> done high in cycle following edge E0+W
//   (W=1 simple ops, W=MULDIV_WAIT mul/div); z_hi/z_lo valid from that cycle until next capture.
//  Capture: mul: {z_hi,z_lo}=alu_result (signed product); div: z_hi=alu_result[63:32]
//   (remainder), z_lo=alu_result[31:0] (quotient); all other ops: z_lo=alu_result[31:0],
//   z_hi=0 regardless of alu_result[63:32].
//  start while busy (EXEC or DONE) is ignored, not queued. Back-to-back: start may be high in
//   the first IDLE cycle after DONE. alu_* outputs hold last values in IDLE/DONE.
// TESTING
//  add: a=5,b=7 -> alu_ctrl=0010, done at E0+1 cycle, z_lo=12, z_hi=0, err=0
//  mul (MULDIV_WAIT=4): a=32'hFFFFFFFF,b=2 -> busy 5 cycles, {z_hi,z_lo}=64'hFFFFFFFF_FFFFFFFE
//  addi: a=10, imm=19'h7FFFF -> alu_b=32'hFFFFFFFF, z_lo=9; div a=17,b=5 -> z_lo=3, z_hi=2
//  illegal opcode 5'b11111 after prior z_lo=12 -> done+err next cycle, z_lo stays 12
//  start re-asserted during mul EXEC with opcode sub -> ignored; only one done, mul result
//  rst_n=0 during mul EXEC -> next cycle IDLE, z=0, busy=0, no done pulse

Source files
------------

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU initiator: decodes one opcode per handshake, drives the ALU,
// waits the op's settle time and captures the double-width result into z_hi/z_lo.
//
// state | meaning
// IDLE  | waiting for start; alu_* hold last values
// EXEC  | ALU inputs held, counter running down to capture
// DONE  | done pulse (err valid), returns to IDLE next edge
module alu_op_sequencer #(
  parameter int REG_SIZE    = 32,
  parameter int MULDIV_WAIT = 4,
  parameter int IMM_WIDTH   = 19
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4:0]            opcode,
  input  logic [REG_SIZE-1:0]   a_in,
  input  logic [REG_SIZE-1:0]   b_in,
  input  logic [IMM_WIDTH-1:0]  imm_in,
  output logic [3:0]            alu_ctrl,
  output logic [REG_SIZE-1:0]   alu_a,
  output logic [REG_SIZE-1:0]   alu_b,
  input  logic [2*REG_SIZE-1:0] alu_result,
  output logic [REG_SIZE-1:0]   z_hi,
  output logic [REG_SIZE-1:0]   z_lo,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int CW = (MULDIV_WAIT < 2) ? 1 : $clog2(MULDIV_WAIT + 1);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] counter;

  logic [3:0]          dec_ctrl;
  logic                dec_legal;
  logic                dec_imm;
  logic                dec_long;
  logic [REG_SIZE-1:0] imm_ext;
  logic                wide_op;

  assign imm_ext = {{(REG_SIZE-IMM_WIDTH){imm_in[IMM_WIDTH-1]}}, imm_in};
  assign busy    = (state != IDLE);
  // Only mul and div produce a meaningful upper word.
  assign wide_op = (alu_ctrl == 4'b1000) || (alu_ctrl == 4'b1001);

  always_comb begin
    dec_ctrl  = 4'b0000;
    dec_legal = 1'b1;
    dec_imm   = 1'b0;
    dec_long  = 1'b0;
    case (opcode)
      5'b00011: dec_ctrl = 4'b0010;
      5'b00100: dec_ctrl = 4'b0011;
      5'b00101: dec_ctrl = 4'b0000;
      5'b00110: dec_ctrl = 4'b0001;
      5'b00111: dec_ctrl = 4'b0100;
      5'b01000: dec_ctrl = 4'b0101;
      5'b01001: dec_ctrl = 4'b0110;
      5'b01010: dec_ctrl = 4'b0111;
      5'b01011: begin dec_ctrl = 4'b0010; dec_imm = 1'b1; end
      5'b01100: begin dec_ctrl = 4'b0000; dec_imm = 1'b1; end
      5'b01101: begin dec_ctrl = 4'b0001; dec_imm = 1'b1; end
      5'b01110: begin dec_ctrl = 4'b1000; dec_long = 1'b1; end
      5'b01111: begin dec_ctrl = 4'b1001; dec_long = 1'b1; end
      5'b10000: dec_ctrl = 4'b1010;
      5'b10001: dec_ctrl = 4'b1011;
      default:  dec_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      counter  <= '0;
      alu_ctrl <= 4'b0000;
      alu_a    <= '0;
      alu_b    <= '0;
      z_hi     <= '0;
      z_lo     <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (dec_legal) begin
              alu_ctrl <= dec_ctrl;
              alu_a    <= a_in;
              alu_b    <= dec_imm ? imm_ext : b_in;
              counter  <= dec_long ? CW'(MULDIV_WAIT) : CW'(1);
              state    <= EXEC;
            end else begin
              // Illegal opcode: skip the ALU entirely and leave Z untouched.
              done  <= 1'b1;
              err   <= 1'b1;
              state <= DONE;
            end
          end
        end
        EXEC: begin
          counter <= counter - CW'(1);
          if (counter == CW'(1)) begin
            z_lo  <= alu_result[REG_SIZE-1:0];
            z_hi  <= wide_op ? alu_result[2*REG_SIZE-1:REG_SIZE] : '0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: behavioural ALU, vector table with scoreboard,
// plus hand sequences for start-while-busy and reset mid-operation.
module tb_alu_op_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [4:0]  opcode;
  logic [31:0] a_in, b_in;
  logic [18:0] imm_in;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_a, alu_b;
  logic [63:0] alu_result;
  logic [31:0] z_hi, z_lo;
  logic        busy, done, err;

  alu_op_sequencer #(.REG_SIZE(32), .MULDIV_WAIT(4), .IMM_WIDTH(19)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .opcode(opcode),
    .a_in(a_in), .b_in(b_in), .imm_in(imm_in),
    .alu_ctrl(alu_ctrl), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .z_hi(z_hi), .z_lo(z_lo), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU; simple ops put junk in the upper word so z_hi clearing is visible.
  always_comb begin
    logic [63:0] aa, bb;
    aa = {{32{alu_a[31]}}, alu_a};
    bb = {{32{alu_b[31]}}, alu_b};
    alu_result = {32'hA5A5_5A5A, 32'h0};
    case (alu_ctrl)
      4'b0010: alu_result[31:0] = alu_a + alu_b;
      4'b0011: alu_result[31:0] = alu_a - alu_b;
      4'b0000: alu_result[31:0] = alu_a & alu_b;
      4'b0001: alu_result[31:0] = alu_a | alu_b;
      4'b0100: alu_result[31:0] = alu_a >> alu_b[4:0];
      4'b0101: alu_result[31:0] = alu_a << alu_b[4:0];
      4'b0110: alu_result[31:0] = 32'(({alu_a, alu_a} >> alu_b[4:0]));
      4'b0111: alu_result[31:0] = 32'(({alu_a, alu_a} << alu_b[4:0]) >> 32);
      4'b1000: alu_result = aa * bb;
      4'b1001: alu_result = (alu_b == 0) ? {32'h0, 32'hFFFF_FFFF}
                                         : {alu_a % alu_b, alu_a / alu_b};
      4'b1010: alu_result[31:0] = -alu_b;
      4'b1011: alu_result[31:0] = ~alu_b;
      default: alu_result = 64'h0;
    endcase
  end

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a, b;
    logic [18:0] imm;
    logic [3:0]  ctrl;
    logic [31:0] eb;
    logic        err;
    logic [31:0] hi, lo;
    int          w;
  } vec_t;

  typedef struct {
    logic [31:0] hi, lo;
    logic        err;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic vec_t mk(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic [18:0] imm,
                              logic [3:0] ctrl, logic [31:0] eb, logic e,
                              logic [31:0] hi, logic [31:0] lo, int w);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.imm = imm; v.ctrl = ctrl; v.eb = eb;
    v.err = e; v.hi = hi; v.lo = lo; v.w = w;
    return v;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'h0, done}, 64'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("z_hi", {32'h0, z_hi}, {32'h0, e.hi});
        check("z_lo", {32'h0, z_lo}, {32'h0, e.lo});
        check("err",  {63'h0, err},  {63'h0, e.err});
      end
    end
  end

  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [18:0] imm);
    @(negedge clk);
    start = 1'b1; opcode = op; a_in = a; b_in = b; imm_in = imm;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    exp_t e;
    int   bc, k;
    e.hi = v.hi; e.lo = v.lo; e.err = v.err;
    exp_q.push_back(e);
    issue(v.op, v.a, v.b, v.imm);
    if (!v.err) begin
      check($sformatf("alu_ctrl[%0d]", idx), {60'h0, alu_ctrl}, {60'h0, v.ctrl});
      check($sformatf("alu_a[%0d]", idx), {32'h0, alu_a}, {32'h0, v.a});
      check($sformatf("alu_b[%0d]", idx), {32'h0, alu_b}, {32'h0, v.eb});
    end
    bc = 0; k = -1;
    while (busy && bc < 30) begin
      if (done && k < 0) k = bc;
      bc++;
      @(posedge clk);
      #1;
    end
    check($sformatf("latency[%0d]", idx), 64'(k), 64'(v.w));
    check($sformatf("busy_cycles[%0d]", idx), 64'(bc), 64'(v.w + 1));
  endtask

  initial begin
    int   d0;
    int   k;
    exp_t e;
    rst_n = 1'b0; start = 1'b0; opcode = '0; a_in = '0; b_in = '0; imm_in = '0;

    tbl.push_back(mk(5'b00011, 32'd5, 32'd7, 19'h0, 4'b0010, 32'd7, 1'b0, 32'h0, 32'd12, 1));
    tbl.push_back(mk(5'b00100, 32'd10, 32'd3, 19'h0, 4'b0011, 32'd3, 1'b0, 32'h0, 32'd7, 1));
    tbl.push_back(mk(5'b00101, 32'hF0F0, 32'hFF00, 19'h0, 4'b0000, 32'hFF00, 1'b0, 32'h0, 32'hF000, 1));
    tbl.push_back(mk(5'b00110, 32'hF0, 32'h0F, 19'h0, 4'b0001, 32'h0F, 1'b0, 32'h0, 32'hFF, 1));
    tbl.push_back(mk(5'b00111, 32'h80, 32'd4, 19'h0, 4'b0100, 32'd4, 1'b0, 32'h0, 32'h8, 1));
    tbl.push_back(mk(5'b01000, 32'h1, 32'd31, 19'h0, 4'b0101, 32'd31, 1'b0, 32'h0, 32'h8000_0000, 1));
    tbl.push_back(mk(5'b01001, 32'h1, 32'd1, 19'h0, 4'b0110, 32'd1, 1'b0, 32'h0, 32'h8000_0000, 1));
    tbl.push_back(mk(5'b01010, 32'h8000_0000, 32'd1, 19'h0, 4'b0111, 32'd1, 1'b0, 32'h0, 32'h1, 1));
    tbl.push_back(mk(5'b01011, 32'd10, 32'd99, 19'h7FFFF, 4'b0010, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'd9, 1));
    tbl.push_back(mk(5'b01100, 32'hFFFF, 32'd99, 19'h000F0, 4'b0000, 32'hF0, 1'b0, 32'h0, 32'hF0, 1));
    tbl.push_back(mk(5'b01101, 32'h100, 32'd99, 19'h40000, 4'b0001, 32'hFFFC_0000, 1'b0, 32'h0, 32'hFFFC_0100, 1));
    tbl.push_back(mk(5'b01110, 32'hFFFF_FFFF, 32'd2, 19'h0, 4'b1000, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4));
    tbl.push_back(mk(5'b01111, 32'd17, 32'd5, 19'h0, 4'b1001, 32'd5, 1'b0, 32'd2, 32'd3, 4));
    tbl.push_back(mk(5'b10000, 32'd99, 32'd5, 19'h0, 4'b1010, 32'd5, 1'b0, 32'h0, 32'hFFFF_FFFB, 1));
    tbl.push_back(mk(5'b10001, 32'd99, 32'd0, 19'h0, 4'b1011, 32'd0, 1'b0, 32'h0, 32'hFFFF_FFFF, 1));
    tbl.push_back(mk(5'b00011, 32'd5, 32'd7, 19'h0, 4'b0010, 32'd7, 1'b0, 32'h0, 32'd12, 1));
    tbl.push_back(mk(5'b11111, 32'd1, 32'd1, 19'h0, 4'b0000, 32'd0, 1'b1, 32'h0, 32'd12, 0));
    tbl.push_back(mk(5'b00000, 32'd1, 32'd1, 19'h0, 4'b0000, 32'd0, 1'b1, 32'h0, 32'd12, 0));

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'h0, busy}, 64'h0);
    check("rst_done", {63'h0, done}, 64'h0);
    check("rst_z", {z_hi, z_lo}, 64'h0);
    check("rst_alu", {28'h0, alu_ctrl, alu_a}, 64'h0);
    @(negedge clk) rst_n = 1'b1;

    foreach (tbl[i]) run_vec(i, tbl[i]);

    // start with sub during mul EXEC must be ignored.
    d0 = done_cnt;
    e.hi = 32'hFFFF_FFFF; e.lo = 32'hFFFF_FFFE; e.err = 1'b0;
    exp_q.push_back(e);
    issue(5'b01110, 32'hFFFF_FFFF, 32'd2, 19'h0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b1; opcode = 5'b00100; a_in = 32'd1; b_in = 32'd1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    k = 0;
    while (busy && k < 30) begin @(posedge clk); #1; k++; end
    repeat (5) @(posedge clk);
    #1;
    check("busy_ignore_done_cnt", 64'(done_cnt - d0), 64'd1);
    check("busy_ignore_idle", {63'h0, busy}, 64'h0);

    // Reset during mul EXEC aborts without a done pulse.
    d0 = done_cnt;
    issue(5'b01110, 32'd3, 32'd3, 19'h0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("abort_busy", {63'h0, busy}, 64'h0);
    check("abort_z", {z_hi, z_lo}, 64'h0);
    check("abort_done", {63'h0, done}, 64'h0);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("abort_no_done", 64'(done_cnt - d0), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
